fp_add_stage: RTL and testbench



---
 rtl/fp_pkg.sv | 30 +++
 rtl/fp_add_stage_if.sv | 26 ++
 rtl/fp_add_sub.sv | 62 ++++++
 rtl/fp_classify.sv | 16 +
 rtl/fp_add_stage.sv | 171 +++++++++++++++++
 tb/tb_fp_add_stage.sv | 172 +++++++++++++++++
 6 files changed

// File: rtl/fp_pkg.sv
// Shared encodings, constants and classification record for the FPU add/compare path.
package fp_pkg;

    typedef enum logic [2:0] {
        FP_FADD = 3'b000,
        FP_FSUB = 3'b001,
        FP_FMIN = 3'b010,
        FP_FMAX = 3'b011,
        FP_FEQ  = 3'b100,
        FP_FLT  = 3'b101,
        FP_FLE  = 3'b110,
        FP_RSVD = 3'b111
    } fp_op_e;

    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

    localparam int NV = 4;
    localparam int DZ = 3;
    localparam int OF = 2;
    localparam int UF = 1;
    localparam int NX = 0;

    typedef struct packed {
        logic is_zero;
        logic is_inf;
        logic is_nan;
        logic is_snan;
    } fp_class_t;

endpackage

// File: rtl/fp_add_stage_if.sv
// Issue-side and writeback-side handshake bundle of the add/compare stage.
interface fp_add_stage_if #(
    parameter int TAG_W = 5
);
    logic             i_valid;
    logic             o_ready;
    logic [2:0]       i_op;
    logic [31:0]      i_a;
    logic [31:0]      i_b;
    logic [TAG_W-1:0] i_rd;
    logic             o_valid;
    logic             i_ready;
    logic [31:0]      o_result;
    logic [TAG_W-1:0] o_rd;
    logic [4:0]       o_flags;

    modport slave (
        input  i_valid, i_op, i_a, i_b, i_rd, i_ready,
        output o_ready, o_valid, o_result, o_rd, o_flags
    );

    modport master (
        output i_valid, i_op, i_a, i_b, i_rd, i_ready,
        input  o_ready, o_valid, o_result, o_rd, o_flags
    );
endinterface

// File: rtl/fp_add_sub.sv
// Combinational adder core for finite normal operands with |a| >= |b|; round to nearest even.
module fp_add_sub (
    input  logic        i_mode,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_result
);
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        lzc27 = 5'd27;
        for (int i = 0; i <= 26; i++) begin
            if (v[i]) lzc27 = 5'(26 - i);
        end
    endfunction

    function automatic logic [24:0] round_rne(input logic [26:0] n);
        logic up;
        up = n[2] && (n[1] || n[0] || n[3]);
        round_rne = {1'b0, n[26:3]} + {24'd0, up};
    endfunction

    logic               sb;
    logic        [7:0]  d;
    logic        [26:0] ma, mb_full, mb, norm;
    logic        [27:0] sum;
    logic        [4:0]  lz;
    logic        [24:0] mant;
    logic signed [9:0]  e;

    always_comb begin
        sb      = i_b[31] ^ i_mode;
        d       = i_a[30:23] - i_b[30:23];
        ma      = {1'b1, i_a[22:0], 3'b000};
        mb_full = {1'b1, i_b[22:0], 3'b000};
        // Alignment keeps guard/round bits and folds everything below into a sticky bit
        if (d >= 8'd27) begin
            mb = 27'd1;
        end else begin
            mb = mb_full >> d;
            if ((mb_full & ((27'd1 << d) - 27'd1)) != 27'd0) mb[0] = 1'b1;
        end
        sum  = (i_a[31] ^ sb) ? ({1'b0, ma} - {1'b0, mb}) : ({1'b0, ma} + {1'b0, mb});
        e    = $signed({2'b00, i_a[30:23]});
        lz   = 5'd0;
        norm = sum[26:0];
        if (sum[27]) begin
            norm = {sum[27:2], sum[1] | sum[0]};
            e    = e + 10'sd1;
        end else begin
            lz   = lzc27(sum[26:0]);
            norm = sum[26:0] << lz;
            e    = e - $signed({5'd0, lz});
        end
        mant = round_rne(norm);
        if (mant[24]) begin
            mant = mant >> 1;
            e    = e + 10'sd1;
        end
        if (e >= 10'sd255)   o_result = {i_a[31], 8'hFF, 23'd0};
        else if (e <= 10'sd0) o_result = {i_a[31], 31'd0};
        else                  o_result = {i_a[31], e[7:0], mant[22:0]};
    end
endmodule

// File: rtl/fp_classify.sv
// Single-precision operand classifier; subnormals are reported as zero.
module fp_classify (
    input  logic [31:0] x,
    output logic        is_zero,
    output logic        is_inf,
    output logic        is_nan,
    output logic        is_snan
);
    logic exp_max;

    assign exp_max = (x[30:23] == 8'hFF);
    assign is_zero = (x[30:23] == 8'h00);
    assign is_inf  = exp_max && (x[22:0] == 23'd0);
    assign is_nan  = exp_max && (x[22:0] != 23'd0);
    assign is_snan = is_nan && !x[22];
endmodule

// File: rtl/fp_add_stage.sv
// Two-stage FADD/FSUB/FMIN/FMAX/FEQ/FLT/FLE unit: stage 1 resolves specials and orders
// operands, stage 2 runs the adder core and applies overflow/underflow fix-up.
module fp_add_stage
    import fp_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic           i_clk,
    input  logic           i_rst,
    fp_add_stage_if.slave  bus
);
    fp_op_e      op_p0;
    fp_class_t   ca, cb;
    logic        is_sub_p0, any_nan, any_snan, both_zero, a_ge_b, mag_eq, a_lt_b, nx_align;
    logic [31:0] a_p0, b_p0, big_p0, small_p0, spec_res_p0;
    logic [30:0] mag_a, mag_b;
    logic [7:0]  exp_diff;
    logic [23:0] align_mask;
    logic        spec_p0, nv_p0, nx_p0;
    logic        s1_adv, s2_adv, accept;

    assign op_p0     = fp_op_e'(bus.i_op);
    assign is_sub_p0 = (op_p0 == FP_FSUB);
    assign a_p0      = bus.i_a;
    assign b_p0      = {bus.i_b[31] ^ is_sub_p0, bus.i_b[30:0]};

    fp_classify u_cls_a (.x(bus.i_a), .is_zero(ca.is_zero), .is_inf(ca.is_inf),
                         .is_nan(ca.is_nan), .is_snan(ca.is_snan));
    fp_classify u_cls_b (.x(bus.i_b), .is_zero(cb.is_zero), .is_inf(cb.is_inf),
                         .is_nan(cb.is_nan), .is_snan(cb.is_snan));

    // Stage 0 -> 1: classification, special-case resolution, magnitude ordering
    always_comb begin
        any_nan    = ca.is_nan || cb.is_nan;
        any_snan   = ca.is_snan || cb.is_snan;
        both_zero  = ca.is_zero && cb.is_zero;
        mag_a      = ca.is_zero ? 31'd0 : a_p0[30:0];
        mag_b      = cb.is_zero ? 31'd0 : b_p0[30:0];
        a_ge_b     = (mag_a >= mag_b);
        mag_eq     = (mag_a == mag_b);
        a_lt_b     = (a_p0[31] != b_p0[31]) ? a_p0[31]
                   : (a_p0[31] ? (a_ge_b && !mag_eq) : !a_ge_b);
        big_p0     = a_ge_b ? a_p0 : b_p0;
        small_p0   = a_ge_b ? b_p0 : a_p0;
        exp_diff   = big_p0[30:23] - small_p0[30:23];
        align_mask = (24'd1 << exp_diff[4:0]) - 24'd1;
        nx_align   = (exp_diff >= 8'd24) || (({1'b1, small_p0[22:0]} & align_mask) != 24'd0);

        spec_p0     = 1'b1;
        spec_res_p0 = 32'd0;
        nv_p0       = 1'b0;
        nx_p0       = 1'b0;
        case (op_p0)
            FP_FMIN, FP_FMAX: begin
                nv_p0 = any_snan;
                if (ca.is_nan && cb.is_nan) spec_res_p0 = CANON_NAN;
                else if (ca.is_nan)         spec_res_p0 = b_p0;
                else if (cb.is_nan)         spec_res_p0 = a_p0;
                else spec_res_p0 = ((op_p0 == FP_FMIN) == a_lt_b) ? a_p0 : b_p0;
            end
            FP_FEQ: begin
                nv_p0          = any_snan;
                spec_res_p0[0] = !any_nan && (both_zero || a_p0 == b_p0);
            end
            FP_FLT: begin
                nv_p0          = any_nan;
                spec_res_p0[0] = !any_nan && !both_zero && a_lt_b;
            end
            FP_FLE: begin
                nv_p0          = any_nan;
                spec_res_p0[0] = !any_nan && (both_zero || a_lt_b || a_p0 == b_p0);
            end
            default: begin
                if (any_nan) begin
                    spec_res_p0 = CANON_NAN;
                    nv_p0       = any_snan;
                end else if (ca.is_inf && cb.is_inf && a_p0[31] != b_p0[31]) begin
                    spec_res_p0 = CANON_NAN;
                    nv_p0       = 1'b1;
                end else if (ca.is_inf)    spec_res_p0 = a_p0;
                else if (cb.is_inf)        spec_res_p0 = b_p0;
                else if (both_zero)        spec_res_p0 = {a_p0[31] & b_p0[31], 31'd0};
                else if (ca.is_zero)       spec_res_p0 = b_p0;
                else if (cb.is_zero)       spec_res_p0 = a_p0;
                else if (mag_eq && a_p0[31] != b_p0[31]) spec_res_p0 = 32'd0;
                else begin
                    spec_p0 = 1'b0;
                    nx_p0   = nx_align;
                end
            end
        endcase
    end

    logic             vld_p1, vld_p2;
    fp_op_e           op_p1;
    logic [TAG_W-1:0] rd_p1, rd_p2;
    logic [31:0]      big_p1, small_p1, spec_res_p1, res_p2;
    logic             spec_p1, nv_p1, nx_p1;
    logic [4:0]       flags_p2;

    assign s2_adv      = !vld_p2 || bus.i_ready;
    assign s1_adv      = !vld_p1 || s2_adv;
    assign accept      = bus.i_valid && s1_adv;
    assign bus.o_ready = s1_adv;

    always_ff @(posedge i_clk) begin
        if (i_rst)       vld_p1 <= 1'b0;
        else if (s1_adv) vld_p1 <= bus.i_valid;
    end

    always_ff @(posedge i_clk) begin
        if (accept) begin
            op_p1       <= op_p0;
            rd_p1       <= bus.i_rd;
            big_p1      <= big_p0;
            small_p1    <= small_p0;
            spec_p1     <= spec_p0;
            spec_res_p1 <= spec_res_p0;
            nv_p1       <= nv_p0;
            nx_p1       <= nx_p0;
        end
    end

    // Stage 1 -> 2: adder core and result fix-up
    logic [31:0] core_res, res_nxt;
    logic [4:0]  flags_nxt;
    logic        arith_p1;

    fp_add_sub u_core (.i_mode(1'b0), .i_a(big_p1), .i_b(small_p1), .o_result(core_res));

    assign arith_p1 = (op_p1 == FP_FADD) || (op_p1 == FP_FSUB) || (op_p1 == FP_RSVD);

    always_comb begin
        res_nxt       = core_res;
        flags_nxt     = 5'd0;
        flags_nxt[NV] = nv_p1;
        flags_nxt[NX] = nx_p1;
        if (!arith_p1 || spec_p1) begin
            res_nxt = spec_res_p1;
        end else if (core_res[30:23] == 8'hFF) begin
            res_nxt       = {core_res[31], 8'hFF, 23'd0};
            flags_nxt[OF] = 1'b1;
            flags_nxt[NX] = 1'b1;
        end else if (core_res[30:23] == 8'h00) begin
            res_nxt       = {core_res[31], 31'd0};
            flags_nxt[UF] = 1'b1;
            flags_nxt[NX] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_p2   <= 1'b0;
            res_p2   <= 32'd0;
            rd_p2    <= '0;
            flags_p2 <= 5'd0;
        end else if (s2_adv) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                res_p2   <= res_nxt;
                rd_p2    <= rd_p1;
                flags_p2 <= flags_nxt;
            end
        end
    end

    assign bus.o_valid  = vld_p2;
    assign bus.o_result = res_p2;
    assign bus.o_rd     = rd_p2;
    assign bus.o_flags  = flags_p2;
endmodule

// File: tb/tb_fp_add_stage.sv
// Directed bench for fp_add_stage: specials, rounding/overflow, compares, backpressure, reset.
module tb_fp_add_stage;
    import fp_pkg::*;

    logic i_clk = 1'b0;
    logic i_rst;
    int   errors = 0;
    int   checks = 0;

    always #5 i_clk = ~i_clk;

    fp_add_stage_if #(.TAG_W(5)) bus ();

    fp_add_stage #(.TAG_W(5)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one op into an empty pipe and checks the 2-cycle latency and the result.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp_res, input logic [4:0] exp_flags);
        bus.i_op    = op;
        bus.i_a     = a;
        bus.i_b     = b;
        bus.i_rd    = rd;
        bus.i_valid = 1'b1;
        bus.i_ready = 1'b1;
        @(negedge i_clk);
        chk({tag, ".ready"}, {31'd0, bus.o_ready}, 32'd1);
        @(posedge i_clk); #1;
        bus.i_valid = 1'b0;
        bus.i_a     = $urandom;
        bus.i_b     = $urandom;
        bus.i_op    = 3'($urandom_range(0, 7));
        @(negedge i_clk);
        chk({tag, ".lat1"}, {31'd0, bus.o_valid}, 32'd0);
        @(negedge i_clk);
        chk({tag, ".valid"}, {31'd0, bus.o_valid}, 32'd1);
        chk({tag, ".res"}, bus.o_result, exp_res);
        chk({tag, ".flags"}, {27'd0, bus.o_flags}, {27'd0, exp_flags});
        chk({tag, ".rd"}, {27'd0, bus.o_rd}, {27'd0, rd});
        @(posedge i_clk); #1;
    endtask

    logic [31:0] bp_exp [4];
    logic [31:0] bp_a   [4];

    initial begin
        i_rst       = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        bus.i_op    = 3'd0;
        bus.i_a     = 32'd0;
        bus.i_b     = 32'd0;
        bus.i_rd    = 5'd0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("rst.valid", {31'd0, bus.o_valid}, 32'd0);
        chk("rst.res", bus.o_result, 32'd0);
        chk("rst.rd", {27'd0, bus.o_rd}, 32'd0);
        chk("rst.flags", {27'd0, bus.o_flags}, 32'd0);
        chk("rst.ready", {31'd0, bus.o_ready}, 32'd1);
        @(posedge i_clk); #1;

        run_op("add_1_2",   FP_FADD, 32'h3F800000, 32'h40000000, 5'd1,  32'h40400000, 5'h00);
        run_op("sub_1_2",   FP_FSUB, 32'h3F800000, 32'h40000000, 5'd2,  32'hBF800000, 5'h00);
        run_op("sub_3_3",   FP_FSUB, 32'h40400000, 32'h40400000, 5'd3,  32'h00000000, 5'h00);
        run_op("inf_minf",  FP_FADD, 32'h7F800000, 32'hFF800000, 5'd4,  32'h7FC00000, 5'h10);
        run_op("flt_qnan",  FP_FLT,  32'h3F800000, 32'h7FC00001, 5'd5,  32'h00000000, 5'h10);
        run_op("add_ovf",   FP_FADD, 32'h7F7FFFFF, 32'h7F7FFFFF, 5'd6,  32'h7F800000, 5'h05);
        run_op("add_nx",    FP_FADD, 32'h4B800000, 32'h3F800000, 5'd7,  32'h4B800000, 5'h01);
        run_op("sub_unf",   FP_FSUB, 32'h00800001, 32'h00800000, 5'd8,  32'h00000000, 5'h03);
        run_op("add_snan",  FP_FADD, 32'h7F800001, 32'h3F800000, 5'd9,  32'h7FC00000, 5'h10);
        run_op("add_inf",   FP_FADD, 32'h7F800000, 32'h3F800000, 5'd10, 32'h7F800000, 5'h00);
        run_op("add_nz_nz", FP_FADD, 32'h80000000, 32'h80000000, 5'd11, 32'h80000000, 5'h00);
        run_op("add_zero",  FP_FADD, 32'h00000000, 32'h40400000, 5'd12, 32'h40400000, 5'h00);
        run_op("rsvd_add",  FP_RSVD, 32'h3F800000, 32'h40000000, 5'd13, 32'h40400000, 5'h00);
        run_op("min_zeros", FP_FMIN, 32'h00000000, 32'h80000000, 5'd14, 32'h80000000, 5'h00);
        run_op("max_qnan",  FP_FMAX, 32'h7FC00000, 32'h40000000, 5'd15, 32'h40000000, 5'h00);
        run_op("max_snan",  FP_FMAX, 32'h7F800001, 32'h3F800000, 5'd16, 32'h3F800000, 5'h10);
        run_op("min_2nan",  FP_FMIN, 32'h7FC00000, 32'hFFC00000, 5'd17, 32'h7FC00000, 5'h00);
        run_op("max_neg",   FP_FMAX, 32'hC0000000, 32'hBF800000, 5'd18, 32'hBF800000, 5'h00);
        run_op("feq_zeros", FP_FEQ,  32'h00000000, 32'h80000000, 5'd19, 32'h00000001, 5'h00);
        run_op("feq_qnan",  FP_FEQ,  32'h7FC00000, 32'h7FC00000, 5'd20, 32'h00000000, 5'h00);
        run_op("fle_1_2",   FP_FLE,  32'h3F800000, 32'h40000000, 5'd21, 32'h00000001, 5'h00);
        run_op("flt_2_1",   FP_FLT,  32'h40000000, 32'h3F800000, 5'd22, 32'h00000000, 5'h00);
        run_op("flt_neg",   FP_FLT,  32'hC0000000, 32'hBF800000, 5'd23, 32'h00000001, 5'h00);

        // Backpressure: 4 back-to-back FADDs x+1.0, downstream stalls in cycles 3..5
        bp_a   = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        bp_exp = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
        begin
            int  idx_in  = 0;
            int  idx_out = 0;
            bit  acc;
            for (int c = 0; c < 14; c++) begin
                bus.i_ready = !(c >= 3 && c <= 5);
                if (idx_in < 4) begin
                    bus.i_op    = FP_FADD;
                    bus.i_a     = bp_a[idx_in];
                    bus.i_b     = 32'h3F800000;
                    bus.i_rd    = 5'(24 + idx_in);
                    bus.i_valid = 1'b1;
                end else begin
                    bus.i_valid = 1'b0;
                end
                @(negedge i_clk);
                chk($sformatf("bp.ready%0d", c), {31'd0, bus.o_ready},
                    {31'd0, !(c >= 3 && c <= 5)});
                acc = bus.o_ready && bus.i_valid;
                if (bus.o_valid && idx_out < 4) begin
                    chk($sformatf("bp.res%0d", c), bus.o_result, bp_exp[idx_out]);
                    chk($sformatf("bp.rd%0d", c), {27'd0, bus.o_rd}, 32'(24 + idx_out));
                    chk($sformatf("bp.flags%0d", c), {27'd0, bus.o_flags}, 32'd0);
                    if (bus.i_ready) idx_out++;
                end
                @(posedge i_clk); #1;
                if (acc) idx_in++;
            end
            chk("bp.issued", 32'(idx_in), 32'd4);
            chk("bp.retired", 32'(idx_out), 32'd4);
        end

        // Reset with two ops in flight
        bus.i_ready = 1'b1;
        bus.i_op    = FP_FADD;
        bus.i_a     = 32'h3F800000;
        bus.i_b     = 32'h40000000;
        bus.i_rd    = 5'd30;
        bus.i_valid = 1'b1;
        @(posedge i_clk); #1;
        bus.i_rd    = 5'd31;
        @(posedge i_clk); #1;
        bus.i_valid = 1'b0;
        @(negedge i_clk);
        chk("rst2.pre_valid", {31'd0, bus.o_valid}, 32'd1);
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("rst2.valid", {31'd0, bus.o_valid}, 32'd0);
        chk("rst2.res", bus.o_result, 32'd0);
        chk("rst2.rd", {27'd0, bus.o_rd}, 32'd0);
        chk("rst2.flags", {27'd0, bus.o_flags}, 32'd0);
        chk("rst2.ready", {31'd0, bus.o_ready}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            chk($sformatf("rst2.drain%0d", k), {31'd0, bus.o_valid}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
